// File: rtl/dvp_pkg.sv
// Shared types and default timing for the DVP camera emulator.
// Imported by the top, the pattern generator and the bench.
package dvp_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_VSYNC,
    ST_VBP,
    ST_ACTIVE,
    ST_VFP
  } state_e;

  typedef enum logic [1:0] {
    PAT_GRAD  = 2'd0,
    PAT_CONST = 2'd1,
    PAT_RAMP  = 2'd2,
    PAT_CHECK = 2'd3
  } pat_e;

  localparam int DEF_H_ACTIVE    = 160;
  localparam int DEF_V_ACTIVE    = 120;
  localparam int DEF_H_BLANK     = 144;
  localparam int DEF_VSYNC_LINES = 3;
  localparam int DEF_V_BP        = 17;
  localparam int DEF_V_FP        = 10;

  function automatic int lineBytes(
    input int hActive,
    input int hBlank
  );
    return hBlank + 2 * hActive;
  endfunction

endpackage

// File: rtl/dvp_camera_emulator_if.sv
// DVP bus as seen between camera (master) and capture path (slave).
// Signal names follow the OV7670 pin names.
interface dvp_camera_emulator_if;

  logic       PCLK;
  logic       VSYNC;
  logic       HREF;
  logic [7:0] DataBus;

  modport master (
    output PCLK,
    output VSYNC,
    output HREF,
    output DataBus
  );

  modport slave (
    input PCLK,
    input VSYNC,
    input HREF,
    input DataBus
  );

endinterface

// File: rtl/dvp_pattern_gen.sv
// Combinational RGB565 test-pattern byte generator.
// lowByte selects the second (low) byte of the current pixel.
module dvp_pattern_gen
  import dvp_pkg::*;
(
  input  pat_e       pattern,
  input  logic [7:0] row,
  input  logic [7:0] col,
  input  logic       lowByte,
  input  logic [7:0] rampIdx,
  output logic [7:0] pixByte
);

  logic chkOn;

  assign chkOn = col[3] ^ row[3];

  always_comb begin
    pixByte = 8'h00;
    unique case (pattern)
      PAT_GRAD:  pixByte = lowByte ? row : col;
      PAT_CONST: pixByte = lowByte ? 8'h55 : 8'hAA;
      PAT_RAMP:  pixByte = rampIdx;
      PAT_CHECK: pixByte = {8{chkOn}};
    endcase
  end

endmodule

// File: rtl/dvp_camera_emulator.sv
// OV7670-style DVP source: PCLK = clk/2, VSYNC/HREF framing, RGB565 patterns.
// Outputs are registered and only move on PCLK falling edges.
module dvp_camera_emulator
  import dvp_pkg::*;
#(
  parameter int H_ACTIVE    = DEF_H_ACTIVE,
  parameter int V_ACTIVE    = DEF_V_ACTIVE,
  parameter int H_BLANK     = DEF_H_BLANK,
  parameter int VSYNC_LINES = DEF_VSYNC_LINES,
  parameter int V_BP        = DEF_V_BP,
  parameter int V_FP        = DEF_V_FP
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 enable,
  input  logic [1:0]           pattern_sel,
  dvp_camera_emulator_if.master cam,
  output logic                 frame_done,
  output logic [7:0]           frame_count
);

  localparam int LINE_BYTES = lineBytes(H_ACTIVE, H_BLANK);

  localparam logic [15:0] LAST_BYTE = 16'(LINE_BYTES - 1);
  localparam logic [15:0] HB        = 16'(H_BLANK);
  localparam logic [15:0] VS_LAST   = 16'(VSYNC_LINES - 1);
  localparam logic [15:0] VBP_LAST  = 16'(V_BP - 1);
  localparam logic [15:0] ACT_LAST  = 16'(V_ACTIVE - 1);
  localparam logic [15:0] VFP_LAST  = 16'(V_FP - 1);

  state_e      state;
  state_e      stateNxt;
  pat_e        pattern;
  pat_e        patNxt;
  logic        pclkQ;
  logic [15:0] byteCnt;
  logic [15:0] byteNxt;
  logic [15:0] lineCnt;
  logic [15:0] lineNxt;
  logic [7:0]  rampIdx;
  logic [7:0]  rampNxt;
  logic        doneNxt;
  logic [7:0]  countNxt;
  logic        lastByte;

  logic        vsyncQ;
  logic        hrefQ;
  logic [7:0]  dataQ;
  logic        vsyncNxt;
  logic        hrefNxt;
  logic [8:0]  offNxt;
  logic [7:0]  genByte;

  assign lastByte = (byteCnt == LAST_BYTE);

  always_comb begin
    stateNxt = state;
    patNxt   = pattern;
    byteNxt  = byteCnt;
    lineNxt  = lineCnt;
    rampNxt  = rampIdx;
    doneNxt  = 1'b0;
    countNxt = frame_count;
    if (pclkQ && state != ST_IDLE) begin
      byteNxt = lastByte ? 16'd0 : byteCnt + 16'd1;
      lineNxt = lastByte ? lineCnt + 16'd1 : lineCnt;
      rampNxt = rampIdx + {7'd0, hrefQ};
    end
    if (pclkQ) begin
      unique case (state)
        ST_IDLE: begin
          if (enable) begin
            stateNxt = ST_VSYNC;
            patNxt   = pat_e'(pattern_sel);
            rampNxt  = 8'd0;
          end
        end
        ST_VSYNC: begin
          if (lastByte && lineCnt == VS_LAST) begin
            stateNxt = ST_VBP;
            lineNxt  = 16'd0;
          end
        end
        ST_VBP: begin
          if (lastByte && lineCnt == VBP_LAST) begin
            stateNxt = ST_ACTIVE;
            lineNxt  = 16'd0;
          end
        end
        ST_ACTIVE: begin
          if (lastByte && lineCnt == ACT_LAST) begin
            stateNxt = ST_VFP;
            lineNxt  = 16'd0;
          end
        end
        ST_VFP: begin
          if (lastByte && lineCnt == VFP_LAST) begin
            doneNxt  = 1'b1;
            countNxt = frame_count + 8'd1;
            lineNxt  = 16'd0;
            rampNxt  = 8'd0;
            // Back-to-back frames re-latch the pattern here
            if (enable) begin
              stateNxt = ST_VSYNC;
              patNxt   = pat_e'(pattern_sel);
            end else begin
              stateNxt = ST_IDLE;
            end
          end
        end
      endcase
    end
  end

  assign vsyncNxt = (stateNxt == ST_VSYNC);
  assign hrefNxt  = (stateNxt == ST_ACTIVE) && (byteNxt >= HB);
  assign offNxt   = 9'(byteNxt - HB);

  dvp_pattern_gen u_gen (
    .pattern (patNxt),
    .row     (lineNxt[7:0]),
    .col     (offNxt[8:1]),
    .lowByte (offNxt[0]),
    .rampIdx (rampNxt),
    .pixByte (genByte)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pclkQ       <= 1'b0;
      state       <= ST_IDLE;
      pattern     <= PAT_GRAD;
      byteCnt     <= 16'd0;
      lineCnt     <= 16'd0;
      rampIdx     <= 8'd0;
      frame_done  <= 1'b0;
      frame_count <= 8'd0;
      vsyncQ      <= 1'b0;
      hrefQ       <= 1'b0;
      dataQ       <= 8'd0;
    end else begin
      pclkQ       <= ~pclkQ;
      state       <= stateNxt;
      pattern     <= patNxt;
      byteCnt     <= byteNxt;
      lineCnt     <= lineNxt;
      rampIdx     <= rampNxt;
      frame_done  <= doneNxt;
      frame_count <= countNxt;
      vsyncQ      <= vsyncNxt;
      hrefQ       <= hrefNxt;
      dataQ       <= hrefNxt ? genByte : 8'd0;
    end
  end

  assign cam.PCLK    = pclkQ;
  assign cam.VSYNC   = vsyncQ;
  assign cam.HREF    = hrefQ;
  assign cam.DataBus = dataQ;

endmodule

// File: tb/tb_dvp_camera_emulator.sv
// Directed bench for dvp_camera_emulator with a 4x3 frame geometry.
// Frame = 84 slots: 24 VSYNC, 12 VBP, 36 active, 12 VFP.
module tb_dvp_camera_emulator;

  localparam int FS = 84;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       enable = 1'b0;
  logic [1:0] pattern_sel = 2'd0;
  logic       frame_done;
  logic [7:0] frame_count;

  dvp_camera_emulator_if cam();

  dvp_camera_emulator #(
    .H_ACTIVE    (4),
    .V_ACTIVE    (3),
    .H_BLANK     (4),
    .VSYNC_LINES (2),
    .V_BP        (1),
    .V_FP        (1)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .enable      (enable),
    .pattern_sel (pattern_sel),
    .cam         (cam),
    .frame_done  (frame_done),
    .frame_count (frame_count)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  int   cyc = 0;
  logic vsPrev = 1'b0;
  int   vsRiseCyc = 0;
  int   doneCyc = 0;
  int   doneCnt = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    vsPrev <= cam.VSYNC;
    if (cam.VSYNC === 1'b1 && vsPrev !== 1'b1) vsRiseCyc <= cyc;
    if (frame_done === 1'b1) begin
      doneCyc <= cyc;
      doneCnt <= doneCnt + 1;
    end
  end

  logic       vsA [FS];
  logic       hrA [FS];
  logic [7:0] dbA [FS];

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic sampleSlot();
    @(posedge cam.PCLK);
    #1;
  endtask

  task automatic waitVs(output int n);
    n = 0;
    for (int i = 1; i <= 400; i++) begin
      sampleSlot();
      if (cam.VSYNC === 1'b1) begin
        n = i;
        break;
      end
    end
  endtask

  // Slot 0 is the VSYNC slot already sampled by waitVs
  task automatic capFrame(input int dropAt);
    for (int i = 0; i < FS; i++) begin
      if (i > 0) sampleSlot();
      vsA[i] = cam.VSYNC;
      hrA[i] = cam.HREF;
      dbA[i] = cam.DataBus;
      if (i == dropAt) begin
        enable = 1'b0;
        pattern_sel = 2'd0;
      end
    end
  endtask

  function automatic logic [8:0] expSlot(input int pat, input int i);
    int k, s, off, col, row;
    logic [7:0] b;
    if (i < 36 || i >= 72) return 9'h000;
    k = (i - 36) / 12;
    s = (i - 36) % 12;
    if (s < 4) return 9'h000;
    off = s - 4;
    col = off / 2;
    row = k;
    case (pat)
      0:       b = (off % 2 == 1) ? 8'(row) : 8'(col);
      1:       b = (off % 2 == 1) ? 8'h55 : 8'hAA;
      2:       b = 8'(k * 8 + off);
      default: b = (((col ^ row) >> 3) & 1) != 0 ? 8'hFF : 8'h00;
    endcase
    return {1'b1, b};
  endfunction

  function automatic int frameErrs(input int pat);
    int err;
    logic [8:0] e;
    err = 0;
    for (int i = 0; i < FS; i++) begin
      e = expSlot(pat, i);
      if (vsA[i] !== (i < 24)) err++;
      if (hrA[i] !== e[8]) err++;
      if (dbA[i] !== e[7:0]) err++;
    end
    return err;
  endfunction

  function automatic int sumVs();
    int c = 0;
    for (int i = 0; i < FS; i++) if (vsA[i] === 1'b1) c++;
    return c;
  endfunction

  function automatic int sumHr();
    int c = 0;
    for (int i = 0; i < FS; i++) if (hrA[i] === 1'b1) c++;
    return c;
  endfunction

  initial begin
    int n, e, togErr, nzErr, vsRun, last, gapBad, vsBad;
    logic prevP, prevD;
    logic [7:0] rowExp [8];
    rowExp = '{8'h00, 8'h01, 8'h01, 8'h01, 8'h02, 8'h01, 8'h03, 8'h01};

    // reset state
    #23;
    chk("rst_pclk", cam.PCLK, 0);
    chk("rst_vsync", cam.VSYNC, 0);
    chk("rst_href", cam.HREF, 0);
    chk("rst_data", cam.DataBus, 0);
    chk("rst_done", frame_done, 0);
    chk("rst_count", frame_count, 0);

    // 1: idle with enable low
    @(negedge clk);
    rst_n = 1'b1;
    togErr = 0;
    nzErr = 0;
    for (int i = 0; i < 500; i++) begin
      prevP = cam.PCLK;
      @(negedge clk);
      if (cam.PCLK === prevP) togErr++;
      if (cam.VSYNC !== 1'b0 || cam.HREF !== 1'b0 ||
          cam.DataBus !== 8'h00 || frame_done !== 1'b0 ||
          frame_count !== 8'h00) nzErr++;
    end
    chk("idle_toggle", togErr, 0);
    chk("idle_quiet", nzErr, 0);

    // 2: gradient, single frame
    pattern_sel = 2'd0;
    enable = 1'b1;
    waitVs(n);
    chk("s2_start", n > 0, 1);
    capFrame(83);
    chk("s2_vs_slots", sumVs(), 24);
    chk("s2_href_slots", sumHr(), 24);
    chk("s2_frame", frameErrs(0), 0);
    e = 0;
    for (int k = 0; k < 8; k++) if (dbA[52 + k] !== rowExp[k]) e++;
    chk("s2_row1", e, 0);
    for (int i = 0; i < 4; i++) sampleSlot();
    chk("s2_done_pulses", doneCnt, 1);
    chk("s2_count", frame_count, 1);
    chk("s2_done_delay", doneCyc - vsRiseCyc, 168);
    chk("s2_idle", cam.VSYNC, 0);

    // 3: byte ramp, two back-to-back frames
    pattern_sel = 2'd2;
    enable = 1'b1;
    waitVs(n);
    chk("s3_start", n > 0, 1);
    capFrame(-1);
    chk("s3_f1_bytes", sumHr(), 24);
    chk("s3_f1_ramp", frameErrs(2), 0);
    waitVs(n);
    chk("s3_b2b", n, 1);
    capFrame(83);
    chk("s3_f2_bytes", sumHr(), 24);
    chk("s3_f2_ramp", frameErrs(2), 0);
    for (int i = 0; i < 4; i++) sampleSlot();
    chk("s3_count", frame_count, 3);

    // 4: constant, enable and pattern_sel dropped in active line 1
    pattern_sel = 2'd1;
    enable = 1'b1;
    waitVs(n);
    chk("s4_start", n > 0, 1);
    capFrame(48);
    chk("s4_frame", frameErrs(1), 0);
    e = 0;
    for (int i = 0; i < 150; i++) begin
      sampleSlot();
      if (cam.VSYNC !== 1'b0) e++;
    end
    chk("s4_no_vsync", e, 0);
    chk("s4_count", frame_count, 4);

    // 5: reset in the middle of active line 2
    pattern_sel = 2'd0;
    enable = 1'b1;
    waitVs(n);
    chk("s5_start", n > 0, 1);
    for (int i = 0; i < 65; i++) sampleSlot();
    chk("s5_href_pre", cam.HREF, 1);
    chk("s5_data_pre", cam.DataBus, 8'h02);
    rst_n = 1'b0;
    #1;
    chk("s5_pclk", cam.PCLK, 0);
    chk("s5_vsync", cam.VSYNC, 0);
    chk("s5_href", cam.HREF, 0);
    chk("s5_data", cam.DataBus, 0);
    chk("s5_done", frame_done, 0);
    chk("s5_count", frame_count, 0);
    @(negedge clk);
    rst_n = 1'b1;
    waitVs(n);
    chk("s5_restart", n > 0, 1);
    vsRun = 1;
    for (int i = 0; i < 40; i++) begin
      sampleSlot();
      if (cam.VSYNC === 1'b1) vsRun++;
      else break;
    end
    chk("s5_vs_slots", vsRun, 24);
    chk("s5_count_after", frame_count, 0);

    // 6: 257 continuous frames
    n = 0;
    last = 0;
    gapBad = 0;
    vsBad = 0;
    e = 0;
    prevD = 1'b0;
    for (int i = 0; i < 257 * 168 + 400 && n < 257; i++) begin
      @(negedge clk);
      if (frame_done === 1'b1 && prevD === 1'b1) e++;
      if (frame_done === 1'b1 && prevD !== 1'b1) begin
        if (n > 0 && cyc - last != 168) gapBad++;
        if (cam.VSYNC !== 1'b1) vsBad++;
        last = cyc;
        n++;
      end
      prevD = frame_done;
    end
    chk("s6_frames", n, 257);
    chk("s6_gap", gapBad, 0);
    chk("s6_vs_follow", vsBad, 0);
    chk("s6_count_wrap", frame_count, 1);
    @(negedge clk);
    chk("s6_done_width", frame_done, 0);
    chk("s6_wide", e, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
